m2_block_scheduler: RTL and testbench

Top-level sequencer for the Milestone 2 decoding pass (inverse transform of 8x8 blocks). Walks every 8x8 block of the Y, U and V pre-IDCT segments in raster order and runs the three block engines (fetch S′ from SRAM, transform, write back pixels) as a three-stage overlapped pipeline over ping-pong buffers. Issues one-cycle start pulses with per-block SRAM base/stride descriptors, collects done pulses, and raises `Stop` when the whole image is decoded. Sits between the top-level milestone FSM and the fetch/transform/write-back engines.

---
 rtl/m2_block_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_m2_block_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m2_block_scheduler.sv
// Milestone 2 block sequencer: overlaps fetch, transform and write-back of 8x8 blocks on ping-pong buffers.
// Build option M2_SCHED_CHROMA_EN: defined schedules Y, U and V; undefined schedules Y only.
module m2_block_scheduler #(
   parameter int Y_COLS  = 40,
   parameter int UV_COLS = 20,
   parameter int ROWS    = 30
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   output logic        Stop,
   output logic        Busy,
   output logic        Buf_sel,
   output logic        Fetch_start,
   output logic [17:0] Fetch_base,
   output logic [8:0]  Fetch_stride,
   input  logic        Fetch_done,
   output logic        Xform_start,
   input  logic        Xform_done,
   output logic        Write_start,
   output logic [17:0] Write_base,
   output logic [8:0]  Write_stride,
   input  logic        Write_done
);

`ifdef M2_SCHED_CHROMA_EN
   localparam int N_BLOCKS = ROWS * (Y_COLS + 2 * UV_COLS);
`else
   localparam int N_BLOCKS = ROWS * Y_COLS;
`endif
   localparam logic [11:0] N_BLK    = 12'(N_BLOCKS);
   localparam logic [11:0] N_EPOCHS = 12'(N_BLOCKS + 2);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH} state_t;

   state_t      state;
   logic [11:0] epoch, epoch_nxt, n_epoch;
   logic [1:0]  seg_p0, seg_p1, seg_p2, n_seg_p0, n_seg_p1, n_seg_p2, adv_seg;
   logic [4:0]  row_p0, row_p1, row_p2, n_row_p0, n_row_p1, n_row_p2, adv_row;
   logic [5:0]  col_p0, col_p1, col_p2, n_col_p0, n_col_p1, n_col_p2, adv_col;
   logic [5:0]  last_col;
   logic        vld_p0, vld_p1, vld_p2, n_vld_p0, n_vld_p1, n_vld_p2;
   logic        pend_f, pend_x, pend_w;
   logic        pend_f_nxt, pend_x_nxt, pend_w_nxt, pend_clear, do_launch;

   // Base addresses use shift-add forms: 2560=2^11+2^9, 1280=2^10+2^8, 640=2^9+2^7.
   function automatic logic [17:0] fetch_base_f(input logic [1:0] s, input logic [4:0] r,
                                                input logic [5:0] c);
      logic [17:0] rr, cc;
      rr = 18'(r);
      cc = 18'(c);
      case (s)
         2'd0:    fetch_base_f = 18'd76800  + (rr << 11) + (rr << 9) + (cc << 3);
         2'd1:    fetch_base_f = 18'd153600 + (rr << 10) + (rr << 8) + (cc << 3);
         default: fetch_base_f = 18'd192000 + (rr << 10) + (rr << 8) + (cc << 3);
      endcase
   endfunction

   function automatic logic [17:0] write_base_f(input logic [1:0] s, input logic [4:0] r,
                                                input logic [5:0] c);
      logic [17:0] rr, cc;
      rr = 18'(r);
      cc = 18'(c);
      case (s)
         2'd0:    write_base_f = (rr << 10) + (rr << 8) + (cc << 2);
         2'd1:    write_base_f = 18'd38400 + (rr << 9) + (rr << 7) + (cc << 2);
         default: write_base_f = 18'd57600 + (rr << 9) + (rr << 7) + (cc << 2);
      endcase
   endfunction

   function automatic logic [8:0] fetch_stride_f(input logic [1:0] s);
      fetch_stride_f = (s == 2'd0) ? 9'd320 : 9'd160;
   endfunction

   function automatic logic [8:0] write_stride_f(input logic [1:0] s);
      write_stride_f = (s == 2'd0) ? 9'd160 : 9'd80;
   endfunction

   assign epoch_nxt  = epoch + 12'd1;
   assign last_col   = (seg_p0 == 2'd0) ? 6'(Y_COLS - 1) : 6'(UV_COLS - 1);
   assign pend_f_nxt = pend_f & ~Fetch_done;
   assign pend_x_nxt = pend_x & ~Xform_done;
   assign pend_w_nxt = pend_w & ~Write_done;
   assign pend_clear = ~(pend_f_nxt | pend_x_nxt | pend_w_nxt);
   assign do_launch  = ((state == S_IDLE) && Start) ||
                       ((state == S_WAIT) && pend_clear && (epoch_nxt != N_EPOCHS));

   // Raster advance of the fetch position; the Y-only build never leaves segment 0.
   always_comb begin
      adv_seg = seg_p0;
      adv_row = row_p0;
      adv_col = col_p0 + 6'd1;
      if (col_p0 == last_col) begin
         adv_col = '0;
         if (row_p0 == 5'(ROWS - 1)) begin
            adv_row = '0;
`ifdef M2_SCHED_CHROMA_EN
            adv_seg = seg_p0 + 2'd1;
`endif
         end else begin
            adv_row = row_p0 + 5'd1;
         end
      end
   end

   // Stage contents for the epoch about to launch: restart from block 0, or shift the pipeline.
   always_comb begin
      n_epoch  = '0;
      n_seg_p0 = '0;  n_row_p0 = '0;  n_col_p0 = '0;
      n_seg_p1 = '0;  n_row_p1 = '0;  n_col_p1 = '0;
      n_seg_p2 = '0;  n_row_p2 = '0;  n_col_p2 = '0;
      n_vld_p0 = 1'b1;
      n_vld_p1 = 1'b0;
      n_vld_p2 = 1'b0;
      if (state != S_IDLE) begin
         n_epoch  = epoch_nxt;
         n_seg_p0 = adv_seg;  n_row_p0 = adv_row;  n_col_p0 = adv_col;
         n_seg_p1 = seg_p0;   n_row_p1 = row_p0;   n_col_p1 = col_p0;
         n_seg_p2 = seg_p1;   n_row_p2 = row_p1;   n_col_p2 = col_p1;
         n_vld_p0 = (epoch_nxt < N_BLK);
         n_vld_p1 = vld_p0;
         n_vld_p2 = vld_p1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= S_IDLE;
         epoch        <= '0;
         seg_p0 <= '0;  row_p0 <= '0;  col_p0 <= '0;  vld_p0 <= 1'b0;
         seg_p1 <= '0;  row_p1 <= '0;  col_p1 <= '0;  vld_p1 <= 1'b0;
         seg_p2 <= '0;  row_p2 <= '0;  col_p2 <= '0;  vld_p2 <= 1'b0;
         pend_f       <= 1'b0;
         pend_x       <= 1'b0;
         pend_w       <= 1'b0;
         Stop         <= 1'b0;
         Busy         <= 1'b0;
         Buf_sel      <= 1'b0;
         Fetch_start  <= 1'b0;
         Xform_start  <= 1'b0;
         Write_start  <= 1'b0;
         Fetch_base   <= '0;
         Fetch_stride <= '0;
         Write_base   <= '0;
         Write_stride <= '0;
      end else begin
         Fetch_start <= 1'b0;
         Xform_start <= 1'b0;
         Write_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start) Stop <= 1'b0;
            end
            S_LAUNCH: begin
               pend_f <= Fetch_start;
               pend_x <= Xform_start;
               pend_w <= Write_start;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               pend_f <= pend_f_nxt;
               pend_x <= pend_x_nxt;
               pend_w <= pend_w_nxt;
               if (pend_clear) begin
                  epoch <= epoch_nxt;
                  if (epoch_nxt == N_EPOCHS) state <= S_FINISH;
               end
            end
            S_FINISH: begin
               Stop  <= 1'b1;
               Busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         // Launch: pulse valid stages; descriptors of idle stages keep their last value.
         if (do_launch) begin
            state   <= S_LAUNCH;
            Busy    <= 1'b1;
            epoch   <= n_epoch;
            Buf_sel <= n_epoch[0];
            seg_p0 <= n_seg_p0;  row_p0 <= n_row_p0;  col_p0 <= n_col_p0;  vld_p0 <= n_vld_p0;
            seg_p1 <= n_seg_p1;  row_p1 <= n_row_p1;  col_p1 <= n_col_p1;  vld_p1 <= n_vld_p1;
            seg_p2 <= n_seg_p2;  row_p2 <= n_row_p2;  col_p2 <= n_col_p2;  vld_p2 <= n_vld_p2;
            Fetch_start <= n_vld_p0;
            Xform_start <= n_vld_p1;
            Write_start <= n_vld_p2;
            if (n_vld_p0) begin
               Fetch_base   <= fetch_base_f(n_seg_p0, n_row_p0, n_col_p0);
               Fetch_stride <= fetch_stride_f(n_seg_p0);
            end
            if (n_vld_p2) begin
               Write_base   <= write_base_f(n_seg_p2, n_row_p2, n_col_p2);
               Write_stride <= write_stride_f(n_seg_p2);
            end
         end
      end
   end

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Directed bench for m2_block_scheduler: engine models answer done a programmable delay after each start.
module tb_m2_block_scheduler;

`ifdef M2_SCHED_CHROMA_EN
   localparam int NB = 2400;
`else
   localparam int NB = 1200;
`endif

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic        Stop, Busy, Buf_sel;
   logic        Fetch_start, Xform_start, Write_start;
   logic [17:0] Fetch_base, Write_base;
   logic [8:0]  Fetch_stride, Write_stride;
   logic        Fetch_done, Xform_done, Write_done;

   int n_checks = 0;
   int n_fail   = 0;
   int unsigned cyc = 0;
   int f_dly = 5, x_dly = 5, w_dly = 5;
   int fcnt = 0, xcnt = 0, wcnt = 0;
   logic f_eng = 1'b0, x_eng = 1'b0, w_eng = 1'b0, inj_x = 1'b0;
   int lcnt   = 0;
   int base_g = 0;

   logic [17:0] fb_log  [0:4095];
   logic [8:0]  fst_log [0:4095];
   logic [17:0] wb_log  [0:4095];
   logic [8:0]  wst_log [0:4095];
   logic [2:0]  st_log  [0:4095];
   logic        bs_log  [0:4095];
   int unsigned cy_log  [0:4095];

   assign Fetch_done = f_eng;
   assign Xform_done = x_eng | inj_x;
   assign Write_done = w_eng;

   m2_block_scheduler dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Busy(Busy), .Buf_sel(Buf_sel),
      .Fetch_start(Fetch_start), .Fetch_base(Fetch_base), .Fetch_stride(Fetch_stride),
      .Fetch_done(Fetch_done), .Xform_start(Xform_start), .Xform_done(Xform_done),
      .Write_start(Write_start), .Write_base(Write_base), .Write_stride(Write_stride),
      .Write_done(Write_done)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   // Engine models: a start seen at a negedge yields a done pulse 'dly' cycles later.
   always @(negedge Clock) begin
      if (Reset) begin
         fcnt <= 0; xcnt <= 0; wcnt <= 0;
         f_eng <= 1'b0; x_eng <= 1'b0; w_eng <= 1'b0;
      end else begin
         if (Fetch_start) begin fcnt <= f_dly; f_eng <= 1'b0; end
         else begin f_eng <= (fcnt == 1); if (fcnt != 0) fcnt <= fcnt - 1; end
         if (Xform_start) begin xcnt <= x_dly; x_eng <= 1'b0; end
         else begin x_eng <= (xcnt == 1); if (xcnt != 0) xcnt <= xcnt - 1; end
         if (Write_start) begin wcnt <= w_dly; w_eng <= 1'b0; end
         else begin w_eng <= (wcnt == 1); if (wcnt != 0) wcnt <= wcnt - 1; end
      end
   end

   always @(negedge Clock) begin
      if (Fetch_start || Xform_start || Write_start) begin
         fb_log[lcnt % 4096]  <= Fetch_base;
         fst_log[lcnt % 4096] <= Fetch_stride;
         wb_log[lcnt % 4096]  <= Write_base;
         wst_log[lcnt % 4096] <= Write_stride;
         st_log[lcnt % 4096]  <= {Fetch_start, Xform_start, Write_start};
         bs_log[lcnt % 4096]  <= Buf_sel;
         cy_log[lcnt % 4096]  <= cyc;
         lcnt <= lcnt + 1;
      end
   end

   function automatic int ix(input int e);
      return (base_g + e) % 4096;
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge Clock);
      if ({Stop, Busy, Buf_sel, Fetch_start, Xform_start, Write_start} !== 6'b0) begin
         n_fail++; $display("FAIL rst_flags: got %b expected 000000",
                            {Stop, Busy, Buf_sel, Fetch_start, Xform_start, Write_start});
      end
      n_checks++;
      if ({Fetch_base, Write_base} !== 36'd0) begin
         n_fail++; $display("FAIL rst_bases: got %0d/%0d expected 0/0", Fetch_base, Write_base);
      end
      n_checks++;
      if ({Fetch_stride, Write_stride} !== 18'd0) begin
         n_fail++; $display("FAIL rst_strides: got %0d/%0d expected 0/0", Fetch_stride, Write_stride);
      end
      n_checks++;
      #1 Reset = 1'b0;
      @(negedge Clock);
      if ({Busy, Fetch_start} !== 2'b00) begin
         n_fail++; $display("FAIL idle_no_start: got %b expected 00", {Busy, Fetch_start});
      end
      n_checks++;
   endtask

   // Epochs 0 and 1 with 5-cycle engines and a stray Xform_done while transform is idle.
   task automatic test_first_epochs();
      #1 Start = 1'b1;
      @(negedge Clock);
      if ({Fetch_start, Xform_start, Write_start, Buf_sel, Busy} !== 5'b10001) begin
         n_fail++; $display("FAIL e0_flags: got %b expected 10001",
                            {Fetch_start, Xform_start, Write_start, Buf_sel, Busy});
      end
      n_checks++;
      if (Fetch_base !== 18'd76800 || Fetch_stride !== 9'd320) begin
         n_fail++; $display("FAIL e0_fetch: got %0d/%0d expected 76800/320", Fetch_base, Fetch_stride);
      end
      n_checks++;
      #1 Start = 1'b0;
      @(negedge Clock);
      #1 inj_x = 1'b1;
      @(negedge Clock);
      #1 inj_x = 1'b0;
      repeat (3) @(negedge Clock);
      if (Fetch_start !== 1'b0) begin
         n_fail++; $display("FAIL e0_early_launch: got %b expected 0", Fetch_start);
      end
      n_checks++;
      @(negedge Clock);
      if ({Fetch_start, Xform_start, Write_start, Buf_sel} !== 4'b1101) begin
         n_fail++; $display("FAIL e1_flags: got %b expected 1101",
                            {Fetch_start, Xform_start, Write_start, Buf_sel});
      end
      n_checks++;
      if (Fetch_base !== 18'd76808) begin
         n_fail++; $display("FAIL e1_fetch_base: got %0d expected 76808", Fetch_base);
      end
      n_checks++;
      #1 begin f_dly = 13; x_dly = 3; w_dly = 3; end
   endtask

   // Epoch 2: Xform_done and Write_done together, Fetch_done 10 cycles later.
   task automatic test_overlap();
      repeat (6) @(negedge Clock);
      if ({Fetch_start, Xform_start, Write_start, Buf_sel} !== 4'b1110) begin
         n_fail++; $display("FAIL e2_flags: got %b expected 1110",
                            {Fetch_start, Xform_start, Write_start, Buf_sel});
      end
      n_checks++;
      if (Fetch_base !== 18'd76816 || Write_base !== 18'd0 || Write_stride !== 9'd160) begin
         n_fail++; $display("FAIL e2_desc: got %0d/%0d/%0d expected 76816/0/160",
                            Fetch_base, Write_base, Write_stride);
      end
      n_checks++;
      #1 begin f_dly = 5; x_dly = 5; w_dly = 5; end
      repeat (13) @(negedge Clock);
      if (Fetch_start !== 1'b0) begin
         n_fail++; $display("FAIL e2_wait_fetch: got %b expected 0", Fetch_start);
      end
      n_checks++;
      @(negedge Clock);
      if (Fetch_start !== 1'b1 || Fetch_base !== 18'd76824 || Write_base !== 18'd4) begin
         n_fail++; $display("FAIL e3_launch: got %b/%0d/%0d expected 1/76824/4",
                            Fetch_start, Fetch_base, Write_base);
      end
      n_checks++;
   endtask

   task automatic test_start_while_busy();
      @(negedge Clock);
      #1 Start = 1'b1;
      @(negedge Clock);
      #1 Start = 1'b0;
      if (Fetch_start !== 1'b0 || Fetch_base !== 18'd76824) begin
         n_fail++; $display("FAIL busy_start_ignored: got %b/%0d expected 0/76824", Fetch_start, Fetch_base);
      end
      n_checks++;
      repeat (4) @(negedge Clock);
      if (Fetch_base !== 18'd76832 || Write_base !== 18'd8 || Buf_sel !== 1'b0) begin
         n_fail++; $display("FAIL e4_desc: got %0d/%0d/%b expected 76832/8/0", Fetch_base, Write_base, Buf_sel);
      end
      n_checks++;
   endtask

   task automatic test_reset_mid();
      repeat (18) @(negedge Clock);
      if (Fetch_start !== 1'b1 || Fetch_base !== 18'd76856 || Buf_sel !== 1'b1) begin
         n_fail++; $display("FAIL e7_launch: got %b/%0d/%b expected 1/76856/1", Fetch_start, Fetch_base, Buf_sel);
      end
      n_checks++;
      repeat (2) @(negedge Clock);
      #1 Reset = 1'b1;
      @(negedge Clock);
      if ({Stop, Busy, Buf_sel, Fetch_start, Xform_start, Write_start} !== 6'b0 ||
          {Fetch_base, Write_base, Fetch_stride, Write_stride} !== 54'd0) begin
         n_fail++; $display("FAIL mid_reset_outputs: got %b %0d %0d %0d %0d expected all 0",
                            {Stop, Busy, Buf_sel, Fetch_start, Xform_start, Write_start},
                            Fetch_base, Write_base, Fetch_stride, Write_stride);
      end
      n_checks++;
      #1 Reset = 1'b0;
      repeat (3) @(negedge Clock);
      if ({Busy, Fetch_start} !== 2'b00) begin
         n_fail++; $display("FAIL mid_reset_idle: got %b expected 00", {Busy, Fetch_start});
      end
      n_checks++;
      #1 Start = 1'b1;
      @(negedge Clock);
      #1 Start = 1'b0;
      if ({Fetch_start, Xform_start, Write_start, Buf_sel} !== 4'b1000 || Fetch_base !== 18'd76800) begin
         n_fail++; $display("FAIL restart_e0: got %b/%0d expected 1000/76800",
                            {Fetch_start, Xform_start, Write_start, Buf_sel}, Fetch_base);
      end
      n_checks++;
      repeat (6) @(negedge Clock);
      if (Xform_start !== 1'b1 || Fetch_base !== 18'd76808) begin
         n_fail++; $display("FAIL restart_e1: got %b/%0d expected 1/76808", Xform_start, Fetch_base);
      end
      n_checks++;
   endtask

   task automatic test_full_pass();
      int unsigned stop_cyc;
      #1 Reset = 1'b1;
      repeat (2) @(negedge Clock);
      #1 begin Reset = 1'b0; f_dly = 1; x_dly = 1; w_dly = 1; end
      @(negedge Clock);
      #1 begin base_g = lcnt; Start = 1'b1; end
      @(negedge Clock);
      #1 Start = 1'b0;
      for (int i = 0; i < 20000 && !Stop; i++) @(negedge Clock);
      stop_cyc = cyc;
      if (Stop !== 1'b1 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL pass_end: Stop/Busy got %b/%b expected 1/0", Stop, Busy);
      end
      n_checks++;
      #1;
      if (lcnt - base_g != NB + 2) begin
         n_fail++; $display("FAIL epoch_count: got %0d expected %0d", lcnt - base_g, NB + 2);
      end
      n_checks++;
      if (stop_cyc != cy_log[ix(NB + 1)] + 3) begin
         n_fail++; $display("FAIL stop_timing: got %0d expected %0d", stop_cyc, cy_log[ix(NB + 1)] + 3);
      end
      n_checks++;
      if (fb_log[ix(40)] !== 18'd79360 || fb_log[ix(42)] !== 18'd79376) begin
         n_fail++; $display("FAIL row1_fetch: got %0d/%0d expected 79360/79376", fb_log[ix(40)], fb_log[ix(42)]);
      end
      n_checks++;
      if (wb_log[ix(42)] !== 18'd1280 || st_log[ix(42)] !== 3'b111 || bs_log[ix(43)] !== 1'b1) begin
         n_fail++; $display("FAIL row1_write: got %0d/%b/%b expected 1280/111/1",
                            wb_log[ix(42)], st_log[ix(42)], bs_log[ix(43)]);
      end
      n_checks++;
      if (st_log[ix(NB)] !== 3'b011 || st_log[ix(NB + 1)] !== 3'b001) begin
         n_fail++; $display("FAIL drain_flags: got %b/%b expected 011/001", st_log[ix(NB)], st_log[ix(NB + 1)]);
      end
      n_checks++;
`ifdef M2_SCHED_CHROMA_EN
      if (fb_log[ix(1200)] !== 18'd153600 || fst_log[ix(1200)] !== 9'd160) begin
         n_fail++; $display("FAIL u_first_fetch: got %0d/%0d expected 153600/160", fb_log[ix(1200)], fst_log[ix(1200)]);
      end
      n_checks++;
      if (wb_log[ix(1202)] !== 18'd38400 || wst_log[ix(1202)] !== 9'd80) begin
         n_fail++; $display("FAIL u_first_write: got %0d/%0d expected 38400/80", wb_log[ix(1202)], wst_log[ix(1202)]);
      end
      n_checks++;
      if (fb_log[ix(2399)] !== 18'd229272 || wb_log[ix(2401)] !== 18'd76236 || fb_log[ix(2400)] !== 18'd229272) begin
         n_fail++; $display("FAIL v_last: got %0d/%0d/%0d expected 229272/76236/229272",
                            fb_log[ix(2399)], wb_log[ix(2401)], fb_log[ix(2400)]);
      end
      n_checks++;
`else
      if (fb_log[ix(1199)] !== 18'd151352 || fb_log[ix(1200)] !== 18'd151352 || fst_log[ix(1200)] !== 9'd320) begin
         n_fail++; $display("FAIL y_last_fetch: got %0d/%0d/%0d expected 151352/151352/320",
                            fb_log[ix(1199)], fb_log[ix(1200)], fst_log[ix(1200)]);
      end
      n_checks++;
      if (wb_log[ix(1201)] !== 18'd37276 || wst_log[ix(1201)] !== 9'd160) begin
         n_fail++; $display("FAIL y_last_write: got %0d/%0d expected 37276/160", wb_log[ix(1201)], wst_log[ix(1201)]);
      end
      n_checks++;
`endif
      @(negedge Clock);
      #1 Start = 1'b1;
      @(negedge Clock);
      #1 Start = 1'b0;
      if (Stop !== 1'b0 || Fetch_start !== 1'b1 || Fetch_base !== 18'd76800) begin
         n_fail++; $display("FAIL second_pass_start: got %b/%b/%0d expected 0/1/76800", Stop, Fetch_start, Fetch_base);
      end
      n_checks++;
      #1 Reset = 1'b1;
      repeat (2) @(negedge Clock);
      #1 Reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_epochs();
      test_overlap();
      test_start_while_busy();
      test_reset_mid();
      test_full_pass();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
